// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO read-side streamer and its skid buffer.
package fifo_stream_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PKT_LEN = 4;

    // The FIFO presents rdata one clock after it samples rd_en.
    localparam int RD_LAT = 1;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry, FIFO-ordered register buffer; the head register drives the stream output directly.
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output occ_t             occ_o,
    output logic [WIDTH-1:0] head_o
);

    occ_t             r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    // Data is cleared along with occupancy so the stream output reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= push_data_i;
                    else               r_tail <= push_data_i;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
                    if (r_occ == 2'd1) begin
                        r_head <= push_data_i;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ_o  = r_occ;
    assign head_o = r_head;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Async-FIFO read-port consumer: safe rd_en issue, latency absorption, valid/ready stream with packet framing.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             rd_en_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    output logic [CNT_W-1:0] words_o,
    output logic             busy_o
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    logic             r_inflight;
    logic [15:0]      r_pkt_cnt;
    logic [CNT_W-1:0] r_words;

    occ_t             w_occ;
    logic [WIDTH-1:0] w_head;
    logic             w_valid;
    logic             w_pop;
    logic [2:0]       w_load;
    logic             w_space;
    logic             w_last;

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (r_inflight),
        .push_data_i (rdata_i),
        .pop_i       (w_pop),
        .occ_o       (w_occ),
        .head_o      (w_head)
    );

    assign w_valid = (w_occ != 2'd0);
    assign w_pop   = w_valid && m_ready_i;
    assign w_load  = {1'b0, w_occ} + {2'b00, r_inflight};
    // A slot is guaranteed if load is below 2, or exactly 2 with a pop freeing one this edge.
    assign w_space = (w_load < 3'd2) || ((w_load == 3'd2) && w_pop);
    // Gating with reset keeps the FIFO from being read while the buffer is held cleared.
    assign rd_en_o = rst_n_i && enable_i && !empty_i && w_space;
    assign w_last  = (r_pkt_cnt == LAST_IDX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight <= 1'b0;
            r_pkt_cnt  <= '0;
            r_words    <= '0;
        end else begin
            r_inflight <= rd_en_o;
            if (w_pop) begin
                r_pkt_cnt <= w_last ? 16'd0 : r_pkt_cnt + 16'd1;
                r_words   <= r_words + 1'b1;
            end
        end
    end

    assign m_valid_o = w_valid;
    assign m_data_o  = w_head;
    assign m_last_o  = w_valid && w_last;
    assign words_o   = r_words;
    assign busy_o    = r_inflight || w_valid;

endmodule
